// File: rtl/audio_proc_pkg.sv
// Shared types and constants for the audio frame processor.
// Holds the channel-mode encoding and the peak meter output width.
package audio_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MUTE = 2'd1,
    MODE_SWAP = 2'd2,
    MODE_MONO = 2'd3
  } mode_e;

  localparam int MODE_COUNT = 4;
  localparam int PEAK_W     = 8;

endpackage

// File: rtl/audio_frame_proc_peak_meter.sv
// One-channel windowed peak meter: saturating magnitude, running max,
// and a latch of the top PEAK_W magnitude bits when the window closes.
module peak_meter
  import audio_proc_pkg::*;
#(
  parameter int width_p = 24
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      sample_en_i,
  input  logic                      win_close_i,
  input  logic signed [width_p-1:0] sample_i,
  output logic [PEAK_W-1:0]         peak_o
);

  // The most negative code has no positive twin, so it clamps to max positive.
  function automatic logic [width_p-1:0] abs_sat(input logic signed [width_p-1:0] x);
    if (x == {1'b1, {(width_p-1){1'b0}}})
      return {1'b0, {(width_p-1){1'b1}}};
    else if (x < 0)
      return width_p'(-x);
    else
      return width_p'(x);
  endfunction

  logic [width_p-1:0] mag;
  logic [width_p-1:0] max_all;
  logic [width_p-1:0] run_max_q;

  assign mag     = abs_sat(sample_i);
  assign max_all = (mag > run_max_q) ? mag : run_max_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_max_q <= '0;
      peak_o    <= '0;
    end else if (sample_en_i) begin
      if (win_close_i) begin
        peak_o    <= max_all[width_p-2 -: PEAK_W];
        run_max_q <= mag;
      end else begin
        run_max_q <= max_all;
      end
    end
  end

endmodule

// File: rtl/audio_frame_proc.sv
// Multi-channel audio frame processor: channel mode, power-of-two attenuation,
// one-deep output register. Optional peak meter under AUDIO_FRAME_PROC_PEAK_EN.
module audio_frame_proc
  import audio_proc_pkg::*;
#(
  parameter int width_p     = 24,
  parameter int channels_p  = 2,
  parameter int shift_max_p = 7,
  parameter int window_p    = 4096
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [channels_p*width_p-1:0]        data_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [channels_p*width_p-1:0]        data_o,
  input  logic                                 mode_step_i,
  input  logic                                 vol_up_i,
  input  logic                                 vol_dn_i,
  output logic [1:0]                           mode_o,
  output logic [$clog2(shift_max_p+1)-1:0]     atten_o,
  output logic [channels_p*PEAK_W-1:0]         peak_o
);

  localparam int LOG_CH = $clog2(channels_p);
  localparam int ATT_W  = $clog2(shift_max_p+1);
  localparam int SUM_W  = width_p + LOG_CH;

  mode_e                         mode_q;
  logic [ATT_W-1:0]              atten_q;
  logic                          accept;
  logic signed [width_p-1:0]     in_s [channels_p];
  logic signed [SUM_W-1:0]       sum;
  logic signed [width_p-1:0]     mono;
  logic signed [width_p-1:0]     sel;
  logic [channels_p*width_p-1:0] proc_flat;
  logic                          vld_p1;
  logic [channels_p*width_p-1:0] data_p1;

  assign ready_o = ~reset_i & (~vld_p1 | ready_i);
  assign accept  = valid_i & ready_o;
  assign valid_o = vld_p1;
  assign data_o  = data_p1;
  assign mode_o  = mode_q;
  assign atten_o = atten_q;

  for (genvar c = 0; c < channels_p; c++) begin : g_unpack
    assign in_s[c] = data_i[c*width_p +: width_p];
  end

  // Control updates land on the same edge as an accept, so that frame uses the old settings.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q  <= MODE_PASS;
      atten_q <= '0;
    end else begin
      if (mode_step_i)
        mode_q <= (mode_q == MODE_MONO) ? MODE_PASS : mode_e'(mode_q + 2'd1);
      if (vol_up_i && !vol_dn_i && atten_q != '0)
        atten_q <= atten_q - 1'b1;
      else if (vol_dn_i && !vol_up_i && atten_q != ATT_W'(shift_max_p))
        atten_q <= atten_q + 1'b1;
    end
  end

  // Stage p0: mode select then attenuation, all combinational from data_i.
  always_comb begin
    sum = '0;
    for (int c = 0; c < channels_p; c++)
      sum = sum + {{LOG_CH{in_s[c][width_p-1]}}, in_s[c]};
    mono      = width_p'(sum >>> LOG_CH);
    sel       = '0;
    proc_flat = '0;
    for (int c = 0; c < channels_p; c++) begin
      case (mode_q)
        MODE_PASS: sel = in_s[c];
        MODE_MUTE: sel = '0;
        MODE_SWAP: sel = in_s[channels_p-1-c];
        default:   sel = mono;
      endcase
      proc_flat[c*width_p +: width_p] = sel >>> atten_q;
    end
  end

  // Stage p1: one-deep output register with valid/ready handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= proc_flat;
    end else if (ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef AUDIO_FRAME_PROC_PEAK_EN
  localparam int CNT_W = (window_p > 1) ? $clog2(window_p) : 1;

  logic [CNT_W-1:0] frame_cnt_q;
  logic             win_close;

  assign win_close = accept && (frame_cnt_q == CNT_W'(window_p-1));

  always_ff @(posedge clk_i) begin
    if (reset_i)
      frame_cnt_q <= '0;
    else if (accept)
      frame_cnt_q <= win_close ? '0 : frame_cnt_q + 1'b1;
  end

  for (genvar c = 0; c < channels_p; c++) begin : g_meter
    peak_meter #(.width_p(width_p)) u_meter (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .sample_en_i (accept),
      .win_close_i (win_close),
      .sample_i    (proc_flat[c*width_p +: width_p]),
      .peak_o      (peak_o[c*PEAK_W +: PEAK_W])
    );
  end
`else
  assign peak_o = '0;
`endif

endmodule

// File: tb/tb_audio_frame_proc.sv
// Scoreboard bench for audio_frame_proc: driver pushes expected frames,
// a negedge monitor pops and compares on each output handshake.
module tb_audio_frame_proc;

  localparam int W = 24, CH = 2, SM = 7, WIN = 4;
`ifdef AUDIO_FRAME_PROC_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_i = 1'b1;
  logic            mode_step_i = 1'b0, vol_up_i = 1'b0, vol_dn_i = 1'b0;
  logic [CH*W-1:0] data_i = '0;
  logic            ready_o, valid_o;
  logic [CH*W-1:0] data_o;
  logic [1:0]      mode_o;
  logic [2:0]      atten_o;
  logic [CH*8-1:0] peak_o;

  int n_checks = 0, n_fail = 0, n_acc = 0, cyc = 0;
  logic [CH*W-1:0] sb [$];
  logic [CH*W-1:0] mon_exp;

  audio_frame_proc #(.width_p(W), .channels_p(CH), .shift_max_p(SM), .window_p(WIN)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .mode_step_i(mode_step_i),
    .vol_up_i(vol_up_i), .vol_dn_i(vol_dn_i), .mode_o(mode_o), .atten_o(atten_o), .peak_o(peak_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got %0h required none", data_o);
      end else begin
        mon_exp = sb.pop_front();
        check("frame", data_o, mon_exp);
      end
    end
  end

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r,
                      input logic [W-1:0] el, input logic [W-1:0] er);
    logic acc;
    int   guard;
    valid_i = 1'b1;
    data_i  = {r, l};
    acc     = 1'b0;
    guard   = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = ready_o;
      if (acc) sb.push_back({er, el});
      @(posedge clk); #1;
      guard++;
    end
    valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept required accept");
    end else begin
      n_acc++;
      check("valid_after_accept", valid_o, 1);
    end
  endtask

  task automatic pulse(input int which);
    case (which)
      0:       mode_step_i = 1'b1;
      1:       vol_up_i = 1'b1;
      2:       vol_dn_i = 1'b1;
      default: begin vol_up_i = 1'b1; vol_dn_i = 1'b1; end
    endcase
    @(posedge clk); #1;
    mode_step_i = 1'b0;
    vol_up_i    = 1'b0;
    vol_dn_i    = 1'b0;
  endtask

  initial begin
    int c0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", ready_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_mode", mode_o, 0);
    check("rst_atten", atten_o, 0);
    check("rst_peak", peak_o, 0);

    send(24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA);
    @(posedge clk); #1;
    check("drain_valid_low", valid_o, 0);

    pulse(0); pulse(0);
    check("mode_swap", mode_o, 2);
    send(W'(100), W'(-100), W'(-100), W'(100));
    pulse(0);
    check("mode_mono", mode_o, 3);
    send(W'(100), W'(300), W'(200), W'(200));
    pulse(0);
    check("mode_wrap_pass", mode_o, 0);

    repeat (3) pulse(2);
    check("atten_3", atten_o, 3);
    send(W'(-64), W'(64), W'(-8), W'(8));
    repeat (7) pulse(2);
    check("atten_sat_7", atten_o, 7);
    send(W'(-64), W'(1000), W'(-1), W'(7));
    pulse(3);
    check("atten_both_hold", atten_o, 7);
    repeat (8) pulse(1);
    check("atten_sat_0", atten_o, 0);

    vol_dn_i = 1'b1;
    send(W'(64), W'(64), W'(64), W'(64));
    vol_dn_i = 1'b0;
    check("atten_after_coincident", atten_o, 1);
    send(W'(64), W'(-64), W'(32), W'(-32));
    pulse(1);
    check("atten_back_0", atten_o, 0);

    ready_i = 1'b0;
    send(W'(11), W'(22), W'(11), W'(22));
    fork
      send(W'(33), W'(44), W'(33), W'(44));
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_ready_low", ready_o, 0);
          check("stall_data_held", data_o, {W'(22), W'(11)});
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
      end
    join

    c0 = cyc;
    send(W'(1), W'(2), W'(1), W'(2));
    send(W'(3), W'(4), W'(3), W'(4));
    send(W'(5), W'(6), W'(5), W'(6));
    send(W'(7), W'(8), W'(7), W'(8));
    check("throughput_cycles", cyc - c0, 4);

    while (n_acc % WIN != 0) send('0, '0, '0, '0);
    send(24'h400000, '0, 24'h400000, '0);
    send('0, '0, '0, '0);
    send('0, '0, '0, '0);
    check("peak_before_close", peak_o, PEAK_ON ? 16'h0000 : 16'h0000);
    send('0, '0, '0, '0);
    check("peak_half_scale", peak_o, PEAK_ON ? 16'h0080 : 16'h0000);
    send(24'h800000, '0, 24'h800000, '0);
    send('0, '0, '0, '0);
    send('0, '0, '0, '0);
    send('0, '0, '0, '0);
    check("peak_most_negative", peak_o, PEAK_ON ? 16'h00FF : 16'h0000);

    pulse(0);
    pulse(2);
    ready_i = 1'b0;
    send(W'(5), W'(6), W'(0), W'(0));
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_data", data_o, 0);
    check("midrst_mode", mode_o, 0);
    check("midrst_atten", atten_o, 0);
    check("midrst_peak", peak_o, 0);
    sb.delete();
    reset_i = 1'b0;
    ready_i = 1'b1;
    send(W'(9), W'(10), W'(9), W'(10));
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
